// File: rtl/id_ex_pipe_if.sv
// ID/EX pipeline register bus: decode-side inputs, forwarding taps,
// and the registered EX-side outputs.
interface id_ex_pipe_if #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 16
);
    logic          flush;
    logic          hold;

    logic          ID_valid;
    logic [AW-1:0] ID_rs;
    logic [AW-1:0] ID_rt;
    logic [AW-1:0] ID_rd;
    logic [DW-1:0] ID_rs_data;
    logic [DW-1:0] ID_rt_data;
    logic [DW-1:0] ID_imm;
    logic [3:0]    ID_alu_op;
    logic          ID_alu_src;
    logic          ID_mem_read;
    logic          ID_mem_write;
    logic          ID_reg_write;

    logic          EXM_reg_write;
    logic [AW-1:0] EXM_rd;
    logic [DW-1:0] EXM_result;
    logic          MWB_reg_write;
    logic [AW-1:0] MWB_rd;
    logic [DW-1:0] MWB_data;

    logic          EX_valid;
    logic [DW-1:0] EX_op_a;
    logic [DW-1:0] EX_op_b;
    logic [DW-1:0] EX_store_data;
    logic [DW-1:0] EX_imm;
    logic [3:0]    EX_alu_op;
    logic          EX_alu_src;
    logic          EX_mem_read;
    logic          EX_mem_write;
    logic          EX_reg_write;
    logic [AW-1:0] EX_rd;
    logic          stall;
    logic [CW-1:0] stall_count;

    modport master (
        output flush, hold,
        output ID_valid, ID_rs, ID_rt, ID_rd,
        output ID_rs_data, ID_rt_data, ID_imm,
        output ID_alu_op, ID_alu_src,
        output ID_mem_read, ID_mem_write, ID_reg_write,
        output EXM_reg_write, EXM_rd, EXM_result,
        output MWB_reg_write, MWB_rd, MWB_data,
        input  EX_valid, EX_op_a, EX_op_b, EX_store_data,
        input  EX_imm, EX_alu_op, EX_alu_src,
        input  EX_mem_read, EX_mem_write, EX_reg_write, EX_rd,
        input  stall, stall_count
    );

    modport slave (
        input  flush, hold,
        input  ID_valid, ID_rs, ID_rt, ID_rd,
        input  ID_rs_data, ID_rt_data, ID_imm,
        input  ID_alu_op, ID_alu_src,
        input  ID_mem_read, ID_mem_write, ID_reg_write,
        input  EXM_reg_write, EXM_rd, EXM_result,
        input  MWB_reg_write, MWB_rd, MWB_data,
        output EX_valid, EX_op_a, EX_op_b, EX_store_data,
        output EX_imm, EX_alu_op, EX_alu_src,
        output EX_mem_read, EX_mem_write, EX_reg_write, EX_rd,
        output stall, stall_count
    );
endinterface

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding
// and load-use bubble insertion.
module id_ex_pipe #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 16
) (
    input  logic        clk,
    input  logic        rst,
    id_ex_pipe_if.slave bus
);

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] rd;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm;
        logic [3:0]    alu_op;
        logic          alu_src;
        logic          mem_read;
        logic          mem_write;
        logic          reg_write;
    } id_ex_t;

    id_ex_t        ex_q;
    id_ex_t        cap;
    logic [CW-1:0] cnt_q;

    logic          lu;
    logic          rd_hit;
    logic          exm_a;
    logic          exm_b;
    logic          mwb_a;
    logic          mwb_b;
    logic [DW-1:0] fwd_a;
    logic [DW-1:0] fwd_b;

    // Side-effect controls are gated so an empty ID slot can never write.
    always_comb begin
        cap           = '0;
        cap.valid     = bus.ID_valid;
        cap.rs        = bus.ID_rs;
        cap.rt        = bus.ID_rt;
        cap.rd        = bus.ID_rd;
        cap.rs_data   = bus.ID_rs_data;
        cap.rt_data   = bus.ID_rt_data;
        cap.imm       = bus.ID_imm;
        cap.alu_op    = bus.ID_alu_op;
        cap.alu_src   = bus.ID_alu_src;
        cap.mem_read  = bus.ID_valid & bus.ID_mem_read;
        cap.mem_write = bus.ID_valid & bus.ID_mem_write;
        cap.reg_write = bus.ID_valid & bus.ID_reg_write;
    end

    always_comb begin
        rd_hit = (ex_q.rd == bus.ID_rs) | (ex_q.rd == bus.ID_rt);
        lu     = ex_q.valid & ex_q.mem_read & ex_q.reg_write
               & (ex_q.rd != '0) & bus.ID_valid & rd_hit;
    end

    assign bus.stall = lu & ~bus.flush & ~bus.hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else if (bus.flush) begin
            ex_q <= '0;
        end else if (!bus.hold) begin
            if (lu) begin
                ex_q <= '0;
                if (cnt_q != {CW{1'b1}}) begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                ex_q <= cap;
            end
        end
    end

    always_comb begin
        exm_a = bus.EXM_reg_write & (bus.EXM_rd != '0)
              & (bus.EXM_rd == ex_q.rs);
        exm_b = bus.EXM_reg_write & (bus.EXM_rd != '0)
              & (bus.EXM_rd == ex_q.rt);
        mwb_a = bus.MWB_reg_write & (bus.MWB_rd != '0)
              & (bus.MWB_rd == ex_q.rs);
        mwb_b = bus.MWB_reg_write & (bus.MWB_rd != '0)
              & (bus.MWB_rd == ex_q.rt);
    end

    // $0 is hard-wired: a stale stored value must not leak through.
    always_comb begin
        fwd_a = ex_q.rs_data;
        if (ex_q.rs == '0) begin
            fwd_a = '0;
        end else if (exm_a) begin
            fwd_a = bus.EXM_result;
        end else if (mwb_a) begin
            fwd_a = bus.MWB_data;
        end
    end

    always_comb begin
        fwd_b = ex_q.rt_data;
        if (ex_q.rt == '0) begin
            fwd_b = '0;
        end else if (exm_b) begin
            fwd_b = bus.EXM_result;
        end else if (mwb_b) begin
            fwd_b = bus.MWB_data;
        end
    end

    assign bus.EX_valid      = ex_q.valid;
    assign bus.EX_op_a       = fwd_a;
    assign bus.EX_op_b       = ex_q.alu_src ? ex_q.imm : fwd_b;
    assign bus.EX_store_data = fwd_b;
    assign bus.EX_imm        = ex_q.imm;
    assign bus.EX_alu_op     = ex_q.alu_op;
    assign bus.EX_alu_src    = ex_q.alu_src;
    assign bus.EX_mem_read   = ex_q.mem_read;
    assign bus.EX_mem_write  = ex_q.mem_write;
    assign bus.EX_reg_write  = ex_q.reg_write;
    assign bus.EX_rd         = ex_q.rd;
    assign bus.stall_count   = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: directed vector table, hold and
// saturation sequences, then random stimulus against a reference model.
module tb_id_ex_pipe;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int CW  = 16;
    localparam int CWS = 4;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    id_ex_pipe_if #(.DW(DW), .AW(AW), .CW(CW))  bus ();
    id_ex_pipe_if #(.DW(DW), .AW(AW), .CW(CWS)) bus_s ();

    id_ex_pipe #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Narrow-counter twin sees identical stimulus; lets saturation be
    // reached in a few dozen cycles.
    id_ex_pipe #(.DW(DW), .AW(AW), .CW(CWS)) dut_s (
        .clk(clk),
        .rst(rst),
        .bus(bus_s)
    );

    assign bus_s.flush         = bus.flush;
    assign bus_s.hold          = bus.hold;
    assign bus_s.ID_valid      = bus.ID_valid;
    assign bus_s.ID_rs         = bus.ID_rs;
    assign bus_s.ID_rt         = bus.ID_rt;
    assign bus_s.ID_rd         = bus.ID_rd;
    assign bus_s.ID_rs_data    = bus.ID_rs_data;
    assign bus_s.ID_rt_data    = bus.ID_rt_data;
    assign bus_s.ID_imm        = bus.ID_imm;
    assign bus_s.ID_alu_op     = bus.ID_alu_op;
    assign bus_s.ID_alu_src    = bus.ID_alu_src;
    assign bus_s.ID_mem_read   = bus.ID_mem_read;
    assign bus_s.ID_mem_write  = bus.ID_mem_write;
    assign bus_s.ID_reg_write  = bus.ID_reg_write;
    assign bus_s.EXM_reg_write = bus.EXM_reg_write;
    assign bus_s.EXM_rd        = bus.EXM_rd;
    assign bus_s.EXM_result    = bus.EXM_result;
    assign bus_s.MWB_reg_write = bus.MWB_reg_write;
    assign bus_s.MWB_rd        = bus.MWB_rd;
    assign bus_s.MWB_data      = bus.MWB_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        valid;
        bit [4:0]  rs, rt, rd;
        bit [31:0] rsd, rtd, imm;
        bit [3:0]  op;
        bit        src, mr, mw, rw;
    } ex_t;

    ex_t         m;
    int unsigned cnt;

    typedef struct {
        bit        iv;
        bit [4:0]  rs, rt, rd;
        bit [31:0] rsd, rtd, imm;
        bit        mr, rw, src;
        bit        xw;
        bit [4:0]  xrd;
        bit [31:0] xres;
        bit        ww;
        bit [4:0]  wrd;
        bit [31:0] wdat;
        bit        fl, ho;
        bit        ev, erw, emr, est;
        bit [31:0] ea, eb;
        int        ecnt;
    } vec_t;

    vec_t tv[11];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit model_lu();
        return m.valid && m.mr && m.rw && m.rd != 0 && bus.ID_valid == 1'b1
            && (m.rd == bus.ID_rs || m.rd == bus.ID_rt);
    endfunction

    function automatic bit [31:0] fwd_m(bit [4:0] a, bit [31:0] v);
        if (a == 0) return 32'd0;
        if (bus.EXM_reg_write && bus.EXM_rd != 0 && bus.EXM_rd == a)
            return bus.EXM_result;
        if (bus.MWB_reg_write && bus.MWB_rd != 0 && bus.MWB_rd == a)
            return bus.MWB_data;
        return v;
    endfunction

    task automatic check_model();
        bit        st;
        bit [31:0] fb;
        int        cs;
        st = model_lu() && !bus.flush && !bus.hold;
        cs = (cnt > 15) ? 15 : int'(cnt);
        chk("stall", 32'(bus.stall), 32'(st));
        chk("ex_valid", 32'(bus.EX_valid), 32'(m.valid));
        chk("reg_write", 32'(bus.EX_reg_write), 32'(m.rw));
        chk("mem_read", 32'(bus.EX_mem_read), 32'(m.mr));
        chk("mem_write", 32'(bus.EX_mem_write), 32'(m.mw));
        chk("stall_count", 32'(bus.stall_count), cnt);
        chk("stall_count_narrow", 32'(bus_s.stall_count), cs);
        if (m.valid) begin
            fb = fwd_m(m.rt, m.rtd);
            chk("op_a", bus.EX_op_a, fwd_m(m.rs, m.rsd));
            chk("op_b", bus.EX_op_b, m.src ? m.imm : fb);
            chk("store_data", bus.EX_store_data, fb);
            chk("rd", 32'(bus.EX_rd), 32'(m.rd));
            chk("alu_op", 32'(bus.EX_alu_op), 32'(m.op));
            chk("alu_src", 32'(bus.EX_alu_src), 32'(m.src));
            chk("imm", bus.EX_imm, m.imm);
        end
    endtask

    // Advance one clock, moving the model by the rules of the stage.
    task automatic tick();
        ex_t         n;
        int unsigned nc;
        bit          l;
        n  = m;
        nc = cnt;
        l  = model_lu();
        if (rst) begin
            n  = '{default: 0};
            nc = 0;
        end else if (bus.flush) begin
            n = '{default: 0};
        end else if (!bus.hold) begin
            if (l) begin
                n = '{default: 0};
                if (nc < 65535) nc++;
            end else begin
                n.valid = bus.ID_valid;
                n.rs    = bus.ID_rs;
                n.rt    = bus.ID_rt;
                n.rd    = bus.ID_rd;
                n.rsd   = bus.ID_rs_data;
                n.rtd   = bus.ID_rt_data;
                n.imm   = bus.ID_imm;
                n.op    = bus.ID_alu_op;
                n.src   = bus.ID_alu_src;
                n.mr    = bus.ID_valid & bus.ID_mem_read;
                n.mw    = bus.ID_valid & bus.ID_mem_write;
                n.rw    = bus.ID_valid & bus.ID_reg_write;
            end
        end
        @(posedge clk);
        m   = n;
        cnt = nc;
        @(negedge clk);
    endtask

    task automatic set_id(bit iv, bit [4:0] rs, bit [4:0] rt, bit [4:0] rd,
                          bit [31:0] rsd, bit [31:0] rtd, bit [31:0] imm,
                          bit mr, bit rw, bit src);
        bus.ID_valid     = iv;
        bus.ID_rs        = rs;
        bus.ID_rt        = rt;
        bus.ID_rd        = rd;
        bus.ID_rs_data   = rsd;
        bus.ID_rt_data   = rtd;
        bus.ID_imm       = imm;
        bus.ID_alu_op    = 4'h2;
        bus.ID_alu_src   = src;
        bus.ID_mem_read  = mr;
        bus.ID_mem_write = 1'b0;
        bus.ID_reg_write = rw;
    endtask

    task automatic clr_fwd();
        bus.EXM_reg_write = 1'b0;
        bus.EXM_rd        = '0;
        bus.EXM_result    = '0;
        bus.MWB_reg_write = 1'b0;
        bus.MWB_rd        = '0;
        bus.MWB_data      = '0;
        bus.flush         = 1'b0;
        bus.hold          = 1'b0;
    endtask

    task automatic drive_rand(bit allow_rst);
        bus.ID_valid      = ($urandom_range(0, 3) != 0);
        bus.ID_rs         = 5'($urandom_range(0, 3));
        bus.ID_rt         = 5'($urandom_range(0, 3));
        bus.ID_rd         = 5'($urandom_range(0, 3));
        bus.ID_rs_data    = $urandom;
        bus.ID_rt_data    = $urandom;
        bus.ID_imm        = $urandom;
        bus.ID_alu_op     = 4'($urandom);
        bus.ID_alu_src    = 1'($urandom);
        bus.ID_mem_read   = ($urandom_range(0, 2) == 0);
        bus.ID_mem_write  = 1'($urandom);
        bus.ID_reg_write  = ($urandom_range(0, 3) != 0);
        bus.EXM_reg_write = 1'($urandom);
        bus.EXM_rd        = 5'($urandom_range(0, 3));
        bus.EXM_result    = $urandom;
        bus.MWB_reg_write = 1'($urandom);
        bus.MWB_rd        = 5'($urandom_range(0, 3));
        bus.MWB_data      = $urandom;
        bus.flush         = ($urandom_range(0, 7) == 0);
        bus.hold          = ($urandom_range(0, 7) == 0);
        rst               = allow_rst && ($urandom_range(0, 63) == 0);
    endtask

    task automatic apply_row(input int i, input vec_t v);
        string s;
        set_id(v.iv, v.rs, v.rt, v.rd, v.rsd, v.rtd, v.imm,
               v.mr, v.rw, v.src);
        bus.EXM_reg_write = v.xw;
        bus.EXM_rd        = v.xrd;
        bus.EXM_result    = v.xres;
        bus.MWB_reg_write = v.ww;
        bus.MWB_rd        = v.wrd;
        bus.MWB_data      = v.wdat;
        bus.flush         = v.fl;
        bus.hold          = v.ho;
        #1;
        s = $sformatf("row%0d", i);
        chk({s, "_valid"}, 32'(bus.EX_valid), 32'(v.ev));
        chk({s, "_reg_write"}, 32'(bus.EX_reg_write), 32'(v.erw));
        chk({s, "_mem_read"}, 32'(bus.EX_mem_read), 32'(v.emr));
        chk({s, "_stall"}, 32'(bus.stall), 32'(v.est));
        chk({s, "_count"}, 32'(bus.stall_count), 32'(v.ecnt));
        chk({s, "_count_narrow"}, 32'(bus_s.stall_count), 32'(v.ecnt));
        if (v.ev) begin
            chk({s, "_op_a"}, bus.EX_op_a, v.ea);
            chk({s, "_op_b"}, bus.EX_op_b, v.eb);
        end
        tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m       = '{default: 0};
        cnt     = 0;

        // iv rs rt rd rsd rtd imm mr rw src | xw xrd xres | ww wrd wdat
        // | fl ho | ev erw emr est ea eb cnt
        tv[0]  = '{1, 1, 2, 3, 5, 7, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,
                   0, 0, 0, 0, 0, 0, 0, 0, 0};
        tv[1]  = '{1, 1, 2, 5, 5, 7, 0, 0, 1, 0, 1, 1, 100, 0, 0, 0,
                   0, 0, 1, 1, 0, 0, 100, 7, 0};
        tv[2]  = '{1, 0, 2, 6, 99, 7, 0, 0, 1, 0, 1, 2, 11, 1, 2, 22,
                   0, 0, 1, 1, 0, 0, 5, 11, 0};
        tv[3]  = '{1, 1, 0, 4, 1000, 0, 8, 1, 1, 1, 1, 0, 55, 0, 0, 0,
                   0, 0, 1, 1, 0, 0, 0, 7, 0};
        tv[4]  = '{1, 4, 1, 7, 0, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,
                   0, 0, 1, 1, 1, 1, 1000, 8, 0};
        tv[5]  = '{1, 4, 1, 7, 0, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,
                   0, 0, 0, 0, 0, 0, 0, 0, 1};
        tv[6]  = '{1, 1, 0, 4, 1000, 0, 8, 1, 1, 1, 0, 0, 0, 1, 4, 32'hABCD,
                   0, 0, 1, 1, 0, 0, 32'hABCD, 3, 1};
        tv[7]  = '{1, 2, 4, 8, 1, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,
                   1, 0, 1, 1, 1, 0, 1000, 8, 1};
        tv[8]  = '{0, 4, 4, 4, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0,
                   0, 0, 0, 0, 0, 0, 0, 0, 1};
        tv[9]  = '{1, 1, 2, 9, 5, 7, 42, 0, 1, 1, 0, 0, 0, 0, 0, 0,
                   0, 0, 0, 0, 0, 0, 0, 0, 1};
        tv[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                   0, 0, 1, 1, 0, 0, 5, 42, 1};

        rst = 1'b1;
        clr_fwd();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        for (int i = 0; i < 11; i++) apply_row(i, tv[i]);

        // Load in EX, dependent in ID, frozen by hold for three cycles.
        clr_fwd();
        set_id(1, 1, 0, 4, 1000, 0, 8, 1, 1, 1);
        #1;
        check_model();
        tick();
        for (int i = 0; i < 3; i++) begin
            set_id(1, 4, 5'($urandom_range(0, 3)), 7,
                   $urandom, $urandom, $urandom, 0, 1, 0);
            bus.hold = 1'b1;
            #1;
            chk("hold_stall", 32'(bus.stall), 32'd0);
            chk("hold_valid", 32'(bus.EX_valid), 32'd1);
            chk("hold_op_a", bus.EX_op_a, 32'd1000);
            chk("hold_op_b", bus.EX_op_b, 32'd8);
            chk("hold_count", 32'(bus.stall_count), 32'd1);
            check_model();
            tick();
        end
        bus.hold = 1'b0;
        #1;
        chk("hold_release_stall", 32'(bus.stall), 32'd1);
        check_model();
        tick();
        #1;
        chk("post_stall_bubble", 32'(bus.EX_valid), 32'd0);
        chk("post_stall_count", 32'(bus.stall_count), 32'd2);
        check_model();
        tick();

        // Self-dependent loads stall every other cycle.
        clr_fwd();
        for (int i = 0; i < 40; i++) begin
            set_id(1, 1, 4, 4, 1000, 0, 8, 1, 1, 1);
            #1;
            check_model();
            tick();
        end
        #1;
        chk("sat_narrow", 32'(bus_s.stall_count), 32'd15);
        chk("count_wide", 32'(bus.stall_count), 32'd22);

        // Reset with random inputs while counters are non-zero.
        for (int i = 0; i < 2; i++) begin
            drive_rand(0);
            rst = 1'b1;
            #1;
            check_model();
            tick();
        end
        drive_rand(0);
        #1;
        chk("rst_valid", 32'(bus.EX_valid), 32'd0);
        chk("rst_reg_write", 32'(bus.EX_reg_write), 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_count", 32'(bus.stall_count), 32'd0);
        chk("rst_count_narrow", 32'(bus_s.stall_count), 32'd0);
        check_model();
        tick();

        for (int i = 0; i < 3000; i++) begin
            drive_rand(1);
            #1;
            check_model();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
